// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue between the bus-side UART controller and the
// serial transmitter. Bytes pushed by the bus are held in a circular buffer
// and handed to the transmitter one at a time over tx_start/tx_data/tx_busy.
// A one-cycle drained pulse marks the end of the last queued character.
// Optional build macro: UART_TX_FIFO_FLUSH_EN adds a synchronous flush input
// that discards everything still queued (the in-flight character completes).
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy,
`ifdef UART_TX_FIFO_FLUSH_EN
    input  logic                  flush,
`endif
    output logic                  drained
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                 state;
    logic [7:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    count;
    logic [DEPTH_LOG2:0]    count_next;
    logic                   flush_now;
    logic                   push;
    logic                   pop;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign level = count;

    // Push/pop qualification; a flush discards the coincident push and
    // suppresses a pop since the queue contents are being thrown away.
    always_comb begin
        push = wr_en & ~full & ~flush_now;
        pop  = (state == IDLE) & ~empty & ~tx_busy & ~flush_now;
    end

    // Next entry count from this edge's accepted push and pop.
    always_comb begin
        count_next = count;
        if (flush_now) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + (DEPTH_LOG2+1)'(1);
                2'b01:   count_next = count - (DEPTH_LOG2+1)'(1);
                default: count_next = count;
            endcase
        end
    end

    // Queue storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, count, registered status flags and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (flush_now) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            count <= count_next;
            full  <= (count_next == DEPTH_CNT);
            empty <= (count_next == '0);
            if (wr_en & full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Transmitter handshake FSM with registered start, data and drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            drained  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            drained  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        state    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state   <= IDLE;
                        drained <= (empty | flush_now) & ~push;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo with a behavioural
// transmitter model and a byte scoreboard. Define UART_TX_FIFO_FLUSH_EN for
// both bench and RTL to exercise the flush input.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       ovf_clr = 1'b0;
    logic       tx_busy;
    logic       full, empty, overflow, tx_start, drained;
    logic [4:0] level;
    logic [7:0] tx_data;
`ifdef UART_TX_FIFO_FLUSH_EN
    logic       flush = 1'b0;
`endif

    logic       model_busy = 1'b0;
    logic       hold_busy = 1'b0;
    int         busy_len = 20;
    int         busy_left = 0;
    int         checks = 0;
    int         errors = 0;
    int         starts = 0;
    int         drains = 0;
    logic [7:0] sb [$];

    typedef struct {
        logic       we;
        logic [7:0] d;
        logic       clr;
        logic       acc;
        logic [4:0] lvl;
        logic       full;
        logic       empty;
        logic       ovf;
    } vec_t;
    vec_t tv [20];

    assign tx_busy = model_busy | hold_busy;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
`ifdef UART_TX_FIFO_FLUSH_EN
        .flush    (flush),
`endif
        .drained  (drained)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input bit track);
        wr_en = 1'b1;
        wr_data = d;
        if (track) sb.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drained(input int bound, input string name);
        for (int i = 0; i < bound && !drained; i++) @(negedge clk);
        check(name, drained, 1);
    endtask

    // Transmitter model: busy rises the cycle after tx_start, holds busy_len edges.
    always @(posedge clk) begin
        logic       sp;
        logic [7:0] sd;
        sp = tx_start;
        sd = tx_data;
        if (drained) drains++;
        #1;
        if (sp) begin
            starts++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got %0h expected no start", sd);
            end else begin
                check("tx_data_order", sd, sb.pop_front());
            end
            model_busy = 1'b1;
            busy_left = busy_len;
        end else if (model_busy) begin
            if (busy_left <= 1) model_busy = 1'b0;
            else busy_left--;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, s0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_drained", drained, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte: latency, pulse width, drained
        busy_len = 20;
        d0 = drains;
        push_byte(8'h41, 1'b1);
        check("t1_level1", level, 1);
        check("t1_nostart", tx_start, 0);
        @(negedge clk);
        check("t1_start", tx_start, 1);
        check("t1_data", tx_data, 8'h41);
        check("t1_level0", level, 0);
        @(negedge clk);
        check("t1_start_width", tx_start, 0);
        wait_drained(100, "t1_drained");
        @(negedge clk);
        check("t1_drained_width", drained, 0);
        repeat (5) @(negedge clk);
        check("t1_drain_count", drains - d0, 1);

        // Table: burst fill with transmitter stalled, overflow and clear
        for (int i = 0; i < 16; i++)
            tv[i] = '{1'b1, 8'(i), 1'b0, 1'b1, 5'(i + 1), (i == 15), 1'b0, 1'b0};
        tv[16] = '{1'b1, 8'hAA, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};
        tv[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0};
        tv[18] = '{1'b1, 8'hBB, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1};
        tv[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0};
        hold_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_en = tv[i].we;
            wr_data = tv[i].d;
            ovf_clr = tv[i].clr;
            if (tv[i].acc) sb.push_back(tv[i].d);
            @(negedge clk);
            wr_en = 1'b0;
            ovf_clr = 1'b0;
            check($sformatf("tv%0d_level", i), level, tv[i].lvl);
            check($sformatf("tv%0d_full", i), full, tv[i].full);
            check($sformatf("tv%0d_empty", i), empty, tv[i].empty);
            check($sformatf("tv%0d_ovf", i), overflow, tv[i].ovf);
        end
        check("tv_no_start_while_busy", starts, 1);

        // Release transmitter: 16 bytes in order, one drained at the end
        busy_len = 3;
        d0 = drains;
        s0 = starts;
        hold_busy = 1'b0;
        wait_drained(2000, "burst_drained");
        repeat (5) @(negedge clk);
        check("burst_starts", starts - s0, 16);
        check("burst_drains", drains - d0, 1);
        check("burst_sb_empty", sb.size(), 0);
        check("burst_empty", empty, 1);

        // Push coinciding with pop at level 3, then wrap through 40 more pushes
        hold_busy = 1'b1;
        for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i), 1'b1);
        check("cpp_level_pre", level, 3);
        hold_busy = 1'b0;
        push_byte(8'h50, 1'b1);
        check("cpp_level", level, 3);
        check("cpp_start", tx_start, 1);
        busy_len = 2;
        for (int k = 0; k < 40; k++) begin
            for (int w = 0; w < 200 && full; w++) @(negedge clk);
            push_byte(8'h60 + 8'(k), 1'b1);
        end
        check("wrap_no_ovf", overflow, 0);
        wait_drained(3000, "wrap_drained");
        repeat (5) @(negedge clk);
        check("wrap_sb_empty", sb.size(), 0);

        // Reset during WAIT_DONE with level 5
        busy_len = 30;
        push_byte(8'h77, 1'b1);
        for (int i = 0; i < 5; i++) push_byte(8'h80 + 8'(i), 1'b1);
        @(negedge clk);
        check("rwd_level5", level, 5);
        check("rwd_sb", sb.size(), 5);
        sb.delete();
        d0 = drains;
        s0 = starts;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rwd_level0", level, 0);
        check("rwd_empty", empty, 1);
        check("rwd_tx_start", tx_start, 0);
        check("rwd_drained", drained, 0);
        repeat (45) @(negedge clk);
        check("rwd_no_start", starts - s0, 0);
        check("rwd_no_drain", drains - d0, 0);

`ifdef UART_TX_FIFO_FLUSH_EN
        // Flush with the transmitter busy at level 6
        busy_len = 30;
        push_byte(8'h88, 1'b1);
        for (int i = 0; i < 6; i++) push_byte(8'h90 + 8'(i), 1'b0);
        check("fl_level6", level, 6);
        s0 = starts;
        d0 = drains;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_level0", level, 0);
        check("fl_empty", empty, 1);
        wait_drained(100, "fl_drained");
        repeat (10) @(negedge clk);
        check("fl_no_start", starts - s0, 0);
        check("fl_drains", drains - d0, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte queue between the bus-side UART controller and the serial transmitter.
- Accepts bytes from the bus, stores them in a circular buffer, and feeds the transmitter one byte at a time over its tx_start/tx_data/tx_busy handshake.
- The CPU can burst-write several bytes without polling tx_busy between characters.
- Raises a drain pulse when the queue empties and the last character has finished.

Parameters:
- DEPTH_LOG2, 4, log2 of queue depth (depth = 16 entries).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  push strobe from the bus controller, one byte per cycle
- wr_data  in  8  byte to push
- full  out  1  queue holds 2^DEPTH_LOG2 entries
- empty  out  1  queue holds 0 entries
- level  out  DEPTH_LOG2+1  current entry count
- overflow  out  1  sticky: a push was dropped because the queue was full
- ovf_clr  in  1  clears overflow
- tx_start  out  1  one-cycle start pulse to the transmitter
- tx_data  out  8  byte presented to the transmitter, held until the next pop
- tx_busy  in  1  transmitter busy; rises the cycle after tx_start and falls after the stop bit
- drained  out  1  one-cycle pulse: queue empty and transmitter idle after the last byte

Behaviour:
- Reset (rst=1 at posedge clk, synchronous, active-high):
  - Pointers and count return to 0; FSM goes to IDLE.
  - full=0, empty=1, level=0, overflow=0, tx_start=0, tx_data=0, drained=0.
  - Queue RAM contents are don't-care.
  - Reset mid-transfer abandons queued bytes. The transmitter is not reset by this block.
- Storage and pointers:
  - wr_ptr and rd_ptr are DEPTH_LOG2 bits and wrap modulo depth with no special case.
  - count is DEPTH_LOG2+1 bits; full = (count == depth); empty = (count == 0).
- Push:
  - wr_en & !full writes mem[wr_ptr]=wr_data and increments wr_ptr.
  - wr_en & full drops the byte and sets overflow. The decision uses full at that edge, even if a pop occurs in the same cycle.
- overflow:
  - Cleared by ovf_clr.
  - If ovf_clr and a dropped push coincide, the set wins.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if !empty & !tx_busy, pop:
    - tx_data <= mem[rd_ptr], tx_start <= 1, rd_ptr++.
    - Go to WAIT_BUSY.
  - WAIT_BUSY:
    - tx_start <= 0, so the pulse is exactly one cycle.
    - On tx_busy=1, go to WAIT_DONE.
    - tx_busy never rising is not recovered; it is a transmitter fault and holds the FSM.
  - WAIT_DONE: on tx_busy=0, go to IDLE.
    - If empty at that edge (no push pending), pulse drained=1 for one cycle.
    - If a push lands on that same edge, drained is not asserted.
- Latency:
  - A push into an empty queue with an idle transmitter writes at edge N.
  - The pop fires at edge N+1, so tx_start is high during cycle N+1..N+2.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Back-to-back characters: a new pop is allowed in the first IDLE cycle after tx_busy falls, giving one idle clock minimum between transmissions.
- level, full and empty are registered from count; they reflect all pushes and pops of the previous edge.

Optional Feature:
- Macro: UART_TX_FIFO_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - flush=1 at a clock edge zeroes pointers and count. The byte already handed to the transmitter completes; the FSM continues its current state normally.
  - A push on the same edge as flush is discarded.
  - drained still fires when that in-flight character finishes.
- When undefined: no flush port; the queue empties only by draining.

Test Plan:
- Push 0x41 into an empty queue, tx_busy model rises 1 cycle after tx_start and is held 20 cycles -> tx_start pulse of 1 cycle with tx_data=0x41; level 1->0; drained pulses once when tx_busy falls.
- Burst-push 0x00..0x0F in 16 consecutive cycles -> full=1 at level=16; the transmitter sees bytes in order 0x00..0x0F, one tx_start per tx_busy fall; drained exactly once at the end.
- With the queue full and the transmitter stalled busy, push 0xAA -> byte dropped, overflow=1, level stays 16; ovf_clr -> overflow=0.
- Push on the same cycle the FSM pops (level=3) -> level stays 3; pointers wrap correctly through index 15->0 over 40 pushes.
- Assert rst during WAIT_DONE with level=5 -> next cycle level=0, empty=1, tx_start=0, FSM IDLE, no drained pulse.
- UART_TX_FIFO_FLUSH_EN: level=6 with the transmitter busy, pulse flush -> level=0 next cycle; the in-flight byte finishes, drained fires, no further tx_start.
